hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Sequences the IF/ID pipeline register and the PC: detects load-use and branch-in-ID data hazards,
//  holds PC and IF/ID for the required stall cycles, bubbles ID/EX, and flushes IF/ID on taken branch/jump.
//  Sits beside the ID stage; drives IF_ID_Write, Flush, Jump inputs of the IF/ID register and PCWrite.
//  Also keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//  REG_W        5   register-specifier width
//  BR_LOAD_CYC  2   stall cycles for a branch in ID depending on a load in EX
//  CNT_W        16  width of the stall/flush event counters (saturating)
// PORTS
//  Clk            in   1      clock, rising edge
//  Reset          in   1      asynchronous, active-high reset
//  ID_Rs          in   REG_W  rs field of instruction in IF/ID
//  ID_Rt          in   REG_W  rt field of instruction in IF/ID
//  ID_UsesRt      in   1      ID instruction reads rt as a source
//  ID_IsBranch    in   1      ID instruction is a conditional branch (compared in ID)
//  ID_BranchTaken in   1      branch comparator result in ID
//  ID_Jump        in   1      ID instruction is j/jal/jr
//  EX_MemRead     in   1      ID/EX holds a load
//  EX_RegWrite    in   1      ID/EX instruction writes a register
//  EX_Rd          in   REG_W  destination register of ID/EX instruction
//  MEM_MemRead    in   1      EX/MEM holds a load
//  MEM_Rd         in   REG_W  destination register of EX/MEM instruction
//  PCWrite        out  1      1 = PC may update
//  IF_ID_Write    out  1      1 = IF/ID may load
//  IF_ID_Flush    out  1      1 = IF/ID loads a NOP (valid only with IF_ID_Write=1)
//  ID_EX_Bubble   out  1      1 = zero ID/EX control signals
//  StallCount     out  CNT_W  number of stall cycles since reset
//  FlushCount     out  CNT_W  number of flush cycles since reset
// BEHAVIOUR
//  Match(r) = (r != 0) && (r == ID_Rs || (ID_UsesRt && r == ID_Rt)).
//  Hazard need N (evaluated only in state RUN, highest N wins):
//   - load-use: EX_MemRead && Match(EX_Rd)                     -> N=1
//   - branch-ALU: ID_IsBranch && EX_RegWrite && !EX_MemRead && Match(EX_Rd) -> N=1
//   - branch-load-in-MEM: ID_IsBranch && MEM_MemRead && Match(MEM_Rd) -> N=1
//   - branch-load-in-EX: ID_IsBranch && EX_MemRead && Match(EX_Rd)   -> N=BR_LOAD_CYC
//  FSM states RUN, STALL; 2-bit down-counter Remain.
//   RUN, N=0: PCWrite=1, IF_ID_Write=1, Bubble=0; Flush=1 iff ID_Jump || (ID_IsBranch && ID_BranchTaken).
//   RUN, N>=1: stall this cycle (PCWrite=0, IF_ID_Write=0, Flush=0, Bubble=1); if N>1 go STALL, Remain=N-1.
//   STALL: same stall outputs; hazard inputs and BranchTaken/Jump ignored; Remain decrements;
//          leave to RUN on the edge where Remain==1. STALL lasts exactly N-1 cycles.
//  Outputs are combinational from state + inputs (zero latency: stall asserts in detection cycle).
//  Priority: stall beats flush; a branch whose operands are hazarded is resolved only after the stall.
//  Counters: StallCount += 1 per stall cycle, FlushCount += 1 per Flush cycle; both saturate at all-ones.
//  Reset (async, any state incl. mid-stall): state=RUN, Remain=0, counters=0; while Reset=1 outputs
//   PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Bubble=1. First cycle after release is normal RUN.
//  Register $0 never causes a hazard.
// TESTING
//  1. EX_MemRead=1, EX_Rd=8, ID_Rs=8 -> one cycle PCWrite=0,IF_ID_Write=0,Bubble=1; next cycle (EX cleared) all 1/0; StallCount=1.
//  2. Branch ID_Rs=9, EX_MemRead=1, EX_Rd=9 -> exactly 2 stall cycles, BranchTaken toggled during stall ignored; StallCount=2.
//  3. ID_IsBranch=1, BranchTaken=1, no hazard -> IF_ID_Flush=1, IF_ID_Write=1, PCWrite=1 for 1 cycle; FlushCount=1.
//  4. EX_MemRead=1, EX_Rd=0, ID_Rs=0 -> no stall; ID_UsesRt=0 with EX_Rd==ID_Rt=5 -> no stall.
//  5. Assert Reset in 1st cycle of 2-cycle branch-load stall -> outputs go to reset values immediately; after release RUN, counters=0.
//  6. Force 2^CNT_W+3 stall cycles -> StallCount holds at all-ones, no wrap.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Controls the PC and the IF/ID register from the ID stage. It detects load-use and
// branch-operand hazards, stalls PC and IF/ID, bubbles ID/EX, and flushes IF/ID when a
// branch is taken or a jump is in ID. It also keeps saturating stall and flush counters.
module hazard_stall_controller #(
   parameter int unsigned REG_W       = 5,
   parameter int unsigned BR_LOAD_CYC = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [REG_W-1:0] ID_Rs,
   input  logic [REG_W-1:0] ID_Rt,
   input  logic             ID_UsesRt,
   input  logic             ID_IsBranch,
   input  logic             ID_BranchTaken,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic             EX_RegWrite,
   input  logic [REG_W-1:0] EX_Rd,
   input  logic             MEM_MemRead,
   input  logic [REG_W-1:0] MEM_Rd,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam logic [1:0] LP_BR_LOAD_N = 2'(BR_LOAD_CYC);

   typedef enum logic {
      S_RUN,
      S_STALL
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_remain;
   logic [1:0]       w_remain_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_match_ex;
   logic             w_match_mem;
   logic [1:0]       w_need;
   logic             w_stall_cyc;

   // Source-operand match against EX and MEM destinations; $0 never matches
   always_comb begin
      w_match_ex  = (EX_Rd != '0) &&
                    ((EX_Rd == ID_Rs) || (ID_UsesRt && (EX_Rd == ID_Rt)));
      w_match_mem = (MEM_Rd != '0) &&
                    ((MEM_Rd == ID_Rs) || (ID_UsesRt && (MEM_Rd == ID_Rt)));
   end

   // Stall cycles required by the instruction in ID; the largest need wins
   always_comb begin
      w_need = 2'd0;
      if (EX_MemRead && w_match_ex)
         w_need = 2'd1;
      if (ID_IsBranch && EX_RegWrite && !EX_MemRead && w_match_ex)
         w_need = 2'd1;
      if (ID_IsBranch && MEM_MemRead && w_match_mem)
         w_need = 2'd1;
      if (ID_IsBranch && EX_MemRead && w_match_ex && (LP_BR_LOAD_N > w_need))
         w_need = LP_BR_LOAD_N;
   end

   // Next-state and pipeline-control outputs; reset forces the stalled/bubbled values
   always_comb begin
      w_state_nxt  = r_state;
      w_remain_nxt = r_remain;
      w_stall_cyc  = 1'b0;
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      case (r_state)
         S_RUN: begin
            if (w_need != 2'd0) begin
               w_stall_cyc = 1'b1;
               if (w_need > 2'd1) begin
                  w_state_nxt  = S_STALL;
                  w_remain_nxt = w_need - 2'd1;
               end
            end else begin
               IF_ID_Flush = ID_Jump || (ID_IsBranch && ID_BranchTaken);
            end
         end
         S_STALL: begin
            w_stall_cyc = 1'b1;
            if (r_remain <= 2'd1) begin
               w_state_nxt  = S_RUN;
               w_remain_nxt = 2'd0;
            end else begin
               w_remain_nxt = r_remain - 2'd1;
            end
         end
         default: begin
            w_state_nxt  = S_RUN;
            w_remain_nxt = 2'd0;
         end
      endcase
      if (w_stall_cyc) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         IF_ID_Flush  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end
      if (Reset) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         IF_ID_Flush  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end
   end

   // State register and remaining-stall down-counter
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state  <= S_RUN;
         r_remain <= 2'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_remain <= w_remain_nxt;
      end
   end

   // Saturating stall/flush event counters
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_cyc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (IF_ID_Flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
// Directed and random stimulus against a cycle-level reference model of the hazard rules.
module tb_hazard_stall_controller;

   localparam int unsigned REG_W = 5;
   localparam int unsigned BR    = 2;
   localparam int unsigned CNT_W = 16;
   localparam longint      MAXC  = (64'd1 << CNT_W) - 1;

   logic             Clk = 1'b0;
   logic             Reset;
   logic [REG_W-1:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
   logic             ID_UsesRt, ID_IsBranch, ID_BranchTaken, ID_Jump;
   logic             EX_MemRead, EX_RegWrite, MEM_MemRead;
   logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble;
   logic [CNT_W-1:0] StallCount, FlushCount;

   int     n_checks = 0;
   int     n_pass   = 0;
   int     m_left   = 0;
   longint m_stall  = 0;
   longint m_flush  = 0;

   hazard_stall_controller #(
      .REG_W      (REG_W),
      .BR_LOAD_CYC(BR),
      .CNT_W      (CNT_W)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .ID_Rs         (ID_Rs),
      .ID_Rt         (ID_Rt),
      .ID_UsesRt     (ID_UsesRt),
      .ID_IsBranch   (ID_IsBranch),
      .ID_BranchTaken(ID_BranchTaken),
      .ID_Jump       (ID_Jump),
      .EX_MemRead    (EX_MemRead),
      .EX_RegWrite   (EX_RegWrite),
      .EX_Rd         (EX_Rd),
      .MEM_MemRead   (MEM_MemRead),
      .MEM_Rd        (MEM_Rd),
      .PCWrite       (PCWrite),
      .IF_ID_Write   (IF_ID_Write),
      .IF_ID_Flush   (IF_ID_Flush),
      .ID_EX_Bubble  (ID_EX_Bubble),
      .StallCount    (StallCount),
      .FlushCount    (FlushCount)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic bit uses(input logic [REG_W-1:0] r);
      return (r != 0) && ((r == ID_Rs) || (ID_UsesRt && (r == ID_Rt)));
   endfunction

   // Stall cycles demanded by the current ID instruction, straight from the hazard rules
   function automatic int need();
      int n = 0;
      if (EX_MemRead && uses(EX_Rd)) n = 1;
      if (ID_IsBranch && EX_RegWrite && !EX_MemRead && uses(EX_Rd) && n < 1) n = 1;
      if (ID_IsBranch && MEM_MemRead && uses(MEM_Rd) && n < 1) n = 1;
      if (ID_IsBranch && EX_MemRead && uses(EX_Rd) && n < BR) n = BR;
      return n;
   endfunction

   task automatic clear_inputs();
      ID_Rs = 0; ID_Rt = 0; EX_Rd = 0; MEM_Rd = 0;
      ID_UsesRt = 0; ID_IsBranch = 0; ID_BranchTaken = 0; ID_Jump = 0;
      EX_MemRead = 0; EX_RegWrite = 0; MEM_MemRead = 0;
   endtask

   // Called with inputs already driven (shortly after a rising edge); checks, then crosses the next edge
   task automatic step(input string tag);
      int  n;
      bit  st, fl;
      @(negedge Clk);
      n  = (m_left > 0) ? 0 : need();
      st = (m_left > 0) || (n > 0);
      fl = !st && (ID_Jump || (ID_IsBranch && ID_BranchTaken));
      check({tag, ".ctl"}, {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble},
            {28'd0, !st, !st, fl, st});
      check({tag, ".scnt"}, 32'(StallCount), 32'(m_stall));
      check({tag, ".fcnt"}, 32'(FlushCount), 32'(m_flush));
      @(posedge Clk);
      if (m_left > 0) m_left--;
      else if (n > 1) m_left = n - 1;
      if (st && m_stall < MAXC) m_stall++;
      if (fl && m_flush < MAXC) m_flush++;
      #1;
   endtask

   initial begin
      clear_inputs();
      Reset = 1'b1;
      #7;
      check("rst.ctl", {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}, 32'h1);
      check("rst.scnt", 32'(StallCount), 32'd0);
      check("rst.fcnt", 32'(FlushCount), 32'd0);
      @(negedge Clk);
      Reset = 1'b0;
      @(posedge Clk); #1;

      // Load-use on rs
      EX_MemRead = 1; EX_Rd = 8; ID_Rs = 8;
      step("lu");
      clear_inputs();
      step("lu.after");
      check("lu.scnt", 32'(StallCount), 32'd1);

      // Branch depending on load in EX: two stall cycles, taken toggles ignored
      ID_IsBranch = 1; ID_Rs = 9; EX_MemRead = 1; EX_Rd = 9;
      step("bl.1");
      EX_MemRead = 0; EX_Rd = 0; ID_BranchTaken = 1;
      step("bl.2");
      ID_BranchTaken = 0;
      step("bl.res");
      clear_inputs();
      check("bl.scnt", 32'(StallCount), 32'd3);

      // Taken branch with no hazard
      ID_IsBranch = 1; ID_BranchTaken = 1;
      step("tk");
      clear_inputs();
      step("tk.after");
      check("tk.fcnt", 32'(FlushCount), 32'd1);

      // $0 and unused rt never stall
      EX_MemRead = 1; EX_Rd = 0; ID_Rs = 0;
      step("r0");
      ID_UsesRt = 0; EX_Rd = 5; ID_Rt = 5; ID_Rs = 1;
      step("nort");
      clear_inputs();

      // Reset in the first cycle of a branch-load stall
      ID_IsBranch = 1; ID_Rs = 9; EX_MemRead = 1; EX_Rd = 9;
      #2;
      check("mr.pre", {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}, 32'h1);
      Reset = 1'b1;
      #1;
      check("mr.ctl", {28'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble}, 32'h1);
      check("mr.scnt", 32'(StallCount), 32'd0);
      check("mr.fcnt", 32'(FlushCount), 32'd0);
      @(posedge Clk);
      @(negedge Clk);
      clear_inputs();
      Reset = 1'b0;
      m_left = 0; m_stall = 0; m_flush = 0;
      @(posedge Clk); #1;
      step("mr.run");
      check("mr.run.scnt", 32'(StallCount), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ID_Rs          = REG_W'($urandom_range(0, 3));
         ID_Rt          = REG_W'($urandom_range(0, 3));
         EX_Rd          = REG_W'($urandom_range(0, 3));
         MEM_Rd         = REG_W'($urandom_range(0, 3));
         ID_UsesRt      = 1'($urandom);
         ID_IsBranch    = ($urandom_range(0, 2) == 0);
         ID_BranchTaken = 1'($urandom);
         ID_Jump        = ($urandom_range(0, 5) == 0);
         EX_MemRead     = ($urandom_range(0, 2) == 0);
         EX_RegWrite    = 1'($urandom);
         MEM_MemRead    = ($urandom_range(0, 2) == 0);
         step("rnd");
      end
      clear_inputs();

      // Stall counter saturation
      EX_MemRead = 1; EX_Rd = 8; ID_Rs = 8;
      for (int i = 0; i < (1 << CNT_W) + 3; i++) step("sat");
      check("sat.scnt", 32'(StallCount), 32'(MAXC));
      clear_inputs();
      step("sat.end");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
